// File: rtl/apb_regfile_slave.sv
// APB register file: ID word at index 0, wait-state insertion, PSLVERR on bad accesses.
// Optional macro APB_STRB_EN enables PSTRB byte masking; otherwise every write is full-word.

module apb_regfile_word #(
  parameter int DW = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   q_o
);
  logic [DW-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    for (int k = 0; k < DW/8; k++)
      if (we_i && be_i[k]) q_d[k*8 +: 8] = wdata_i[k*8 +: 8];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

module apb_regfile_slave #(
  parameter int          PADDR_SIZE  = 8,
  parameter int          PDATA_SIZE  = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic [PADDR_SIZE-1:0]          PADDR,
  input  logic                           PWRITE,
  input  logic [PDATA_SIZE/8-1:0]        PSTRB,
  input  logic [PDATA_SIZE-1:0]          PWDATA,
  output logic [PDATA_SIZE-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*PDATA_SIZE-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);
  localparam int NB  = PDATA_SIZE/8;
  localparam int LSB = $clog2(NB);
  localparam logic [PADDR_SIZE-1:0] ALIGN_MASK = PADDR_SIZE'((1 << LSB) - 1);
  localparam logic [PDATA_SIZE-1:0] ID_W       = PDATA_SIZE'(ID_VALUE);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                               state_q, state_d;
  logic [3:0]                           cnt_q, cnt_d;
  logic [NUM_REGS-1:0]                  wr_pulse_q, wr_pulse_d;
  logic [NUM_REGS-1:0][PDATA_SIZE-1:0]  regs_w;
  logic [NUM_REGS-1:0]                  hit;
  logic [PADDR_SIZE-1:0]                idx;
  logic [PDATA_SIZE-1:0]                rdata;
  logic [NB-1:0]                        be;
  logic                                 complete, err, wr_en;

  // Decode is live off the bus; the master holds address/control stable through ACCESS.
  assign idx = PADDR >> LSB;
  assign err = (|(PADDR & ALIGN_MASK)) || (32'(idx) >= 32'(NUM_REGS)) || (PWRITE && hit[0]);

  always_comb begin
    hit   = '0;
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == PADDR_SIZE'(i)) begin
        hit[i] = 1'b1;
        rdata  = regs_w[i];
      end
    end
  end

  assign complete = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
  assign wr_en    = complete && !err && PWRITE;
  assign PREADY   = complete;
  assign PSLVERR  = complete && err;
  assign PRDATA   = (complete && !err && !PWRITE) ? rdata : '0;

`ifdef APB_STRB_EN
  assign be = PSTRB;
`else
  assign be = '1;
  logic unused_strb;
  assign unused_strb = ^PSTRB;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_pulse_d = wr_en ? hit : '0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        // A dropped PSEL/PENABLE abandons the transfer silently.
        if (!PSEL || !PENABLE)    state_d = IDLE;
        else if (cnt_q == 4'd0)   state_d = IDLE;
        else                      cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign regs_w[0] = ID_W;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    apb_regfile_word #(.DW(PDATA_SIZE)) u_word (
      .clk_i  (PCLK),
      .rst_ni (PRESETn),
      .we_i   (wr_en && hit[i]),
      .be_i   (be),
      .wdata_i(PWDATA),
      .q_o    (regs_w[i])
    );
  end

  assign regs_o     = regs_w;
  assign wr_pulse_o = wr_pulse_q;
endmodule
